traffic_light_monitor: RTL and testbench

Passive checker on the four 2-bit light buses driven by the four-way traffic controller. Decodes the active phase each cycle and verifies three properties:
- at most one direction is non-red;
- phases advance in the fixed rotation;
- each phase is held for exactly DWELL cycles.

Reports the decoded phase, a completed-rotation count, and sticky error flags. Sits beside the controller in the top level and in benches as the receiving end of its light interface.

---
 rtl/traffic_light_monitor_if.sv | 20 ++
 rtl/traffic_light_monitor.sv | 185 ++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_monitor_if
//  Purpose  : Four-way traffic light bus. The controller drives it through
//             the master modport; the monitor observes it through the slave
//             modport.
//  Signals  : n_lights, s_lights, e_lights, w_lights  (2 bits each)
//             2'b10 green, 2'b01 yellow, 2'b00 red, 2'b11 illegal
//  Revision : 1.0  initial release
// ============================================================================
interface traffic_light_monitor_if;
   logic [1:0] n_lights;
   logic [1:0] s_lights;
   logic [1:0] e_lights;
   logic [1:0] w_lights;

   modport master (output n_lights, s_lights, e_lights, w_lights);
   modport slave  (input  n_lights, s_lights, e_lights, w_lights);
endinterface
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_monitor
//  Purpose  : Passive checker for the four-way traffic controller. Decodes
//             the active phase every cycle and checks one-hot non-red
//             directions, fixed phase rotation and an exact per-phase dwell.
//  Ports    : clk             system clock, rising edge
//             rst_n           asynchronous active-low reset
//             lights_if       light bus (slave modport)
//             phase_o         last legal decoded phase (dir,yellow)
//             phase_valid_o   high while locked/tracking
//             dwell_o         samples of the current phase so far
//             rotations_o     accepted WEST_Y->NORTH transitions (wraps)
//             err_conflict_o  sticky: illegal light pattern
//             err_order_o     sticky: out-of-rotation transition
//             err_dwell_o     sticky: phase held too short or too long
//  Params   : DWELL (>=2) cycles each phase must be held
//  Revision : 1.0  initial release
// ============================================================================
module traffic_light_monitor #(
   parameter int DWELL = 8,
   localparam int CW   = $clog2(DWELL + 1)
) (
   input  wire logic                    clk,
   input  wire logic                    rst_n,
   traffic_light_monitor_if.slave       lights_if,
   output logic [2:0]                   phase_o,
   output logic                         phase_valid_o,
   output logic [CW-1:0]                dwell_o,
   output logic [7:0]                   rotations_o,
   output logic                         err_conflict_o,
   output logic                         err_order_o,
   output logic                         err_dwell_o
);

   localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOCK  = 2'd1,
      S_TRACK = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    phase_q, phase_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] dwell_q, dwell_d;
   logic [7:0]    rot_q, rot_d;
   logic          econf_q, econf_d;
   logic          eord_q, eord_d;
   logic          edw_q, edw_d;

   // ---------------------------------------------------------------------
   // Pattern decode: legal only with exactly one non-red bus and no 11.
   // ---------------------------------------------------------------------
   logic [1:0] bus [4];
   logic [2:0] nonred_cnt;
   logic       any_illegal;
   logic [1:0] dir;
   logic       yel;
   logic       legal;
   logic [2:0] p;

   always_comb begin
      bus[0]      = lights_if.n_lights;
      bus[1]      = lights_if.s_lights;
      bus[2]      = lights_if.e_lights;
      bus[3]      = lights_if.w_lights;
      nonred_cnt  = 3'd0;
      any_illegal = 1'b0;
      dir         = 2'd0;
      yel         = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus[i] == 2'b11) begin
            any_illegal = 1'b1;
         end else if (bus[i] != 2'b00) begin
            nonred_cnt = nonred_cnt + 3'd1;
            dir        = 2'(i);
            yel        = bus[i][0];
         end
      end
      legal = !any_illegal && (nonred_cnt == 3'd1);
      p     = {dir, yel};
   end

   // ---------------------------------------------------------------------
   // Next-state logic. Checks are ordered conflict > order > dwell so that
   // a single offending sample sets exactly one flag.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      dwell_d = dwell_q;
      rot_d   = rot_q;
      econf_d = econf_q;
      eord_d  = eord_q;
      edw_d   = edw_q;

      unique case (state_q)
         S_IDLE: begin
            if (legal) begin
               state_d = S_LOCK;
               phase_d = p;
               dwell_d = CW'(1);
            end else begin
               state_d = S_FAULT;
               econf_d = 1'b1;
            end
         end
         S_LOCK, S_TRACK: begin
            if (!legal) begin
               state_d = S_FAULT;
               econf_d = 1'b1;
            end else if (p == phase_q) begin
               // Counter saturates: an overlong phase faults rather than wraps.
               if (dwell_q == DWELL_MAX) begin
                  state_d = S_FAULT;
                  edw_d   = 1'b1;
               end else begin
                  dwell_d = dwell_q + CW'(1);
               end
            end else if (p == phase_q + 3'd1) begin
               // The locked-on phase was seen only partially, so its length
               // is not judged; its successor starts full tracking.
               if (state_q == S_LOCK) begin
                  state_d = S_TRACK;
                  phase_d = p;
                  dwell_d = CW'(1);
               end else if (dwell_q == DWELL_MAX) begin
                  phase_d = p;
                  dwell_d = CW'(1);
                  if (p == 3'd0) begin
                     rot_d = rot_q + 8'd1;
                  end
               end else begin
                  state_d = S_FAULT;
                  edw_d   = 1'b1;
               end
            end else begin
               state_d = S_FAULT;
               eord_d  = 1'b1;
            end
         end
         default: begin
            // FAULT is absorbing; everything holds until reset.
            state_d = S_FAULT;
         end
      endcase

      valid_d = (state_d == S_LOCK) || (state_d == S_TRACK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         phase_q <= 3'd0;
         valid_q <= 1'b0;
         dwell_q <= '0;
         rot_q   <= 8'd0;
         econf_q <= 1'b0;
         eord_q  <= 1'b0;
         edw_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         valid_q <= valid_d;
         dwell_q <= dwell_d;
         rot_q   <= rot_d;
         econf_q <= econf_d;
         eord_q  <= eord_d;
         edw_q   <= edw_d;
      end
   end

   assign phase_o        = phase_q;
   assign phase_valid_o  = valid_q;
   assign dwell_o        = dwell_q;
   assign rotations_o    = rot_q;
   assign err_conflict_o = econf_q;
   assign err_order_o    = eord_q;
   assign err_dwell_o    = edw_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_monitor
//  Purpose  : Self-checking bench for traffic_light_monitor. Stimulus pushes
//             the expected post-edge outputs into a queue; a monitor pops and
//             compares one entry after each rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_light_monitor;

   localparam int DWELL = 8;
   localparam int CW    = $clog2(DWELL + 1);
   localparam int OW    = 3 + 1 + CW + 8 + 3;

   typedef logic [OW-1:0] obs_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   traffic_light_monitor_if lif ();

   logic [2:0]    phase_o;
   logic          phase_valid_o;
   logic [CW-1:0] dwell_o;
   logic [7:0]    rotations_o;
   logic          err_conflict_o;
   logic          err_order_o;
   logic          err_dwell_o;

   traffic_light_monitor #(.DWELL(DWELL)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lights_if      (lif),
      .phase_o        (phase_o),
      .phase_valid_o  (phase_valid_o),
      .dwell_o        (dwell_o),
      .rotations_o    (rotations_o),
      .err_conflict_o (err_conflict_o),
      .err_order_o    (err_order_o),
      .err_dwell_o    (err_dwell_o)
   );

   int         checks = 0;
   int         errors = 0;
   obs_t       exp_q[$];
   string      name_q[$];
   logic [7:0] e_rot = 8'd0;

   function automatic obs_t mk(input logic [2:0] ph, input logic v, input int d,
                               input logic [7:0] r, input logic [2:0] err);
      return {ph, v, CW'(d), r, err};
   endfunction

   // Packed {n,s,e,w} light codes for a legal phase.
   function automatic logic [7:0] lights_of(input logic [2:0] ph);
      logic [1:0] code;
      logic [7:0] out;
      code = ph[0] ? 2'b01 : 2'b10;
      out  = 8'h00;
      case (ph[2:1])
         2'd0:    out[7:6] = code;
         2'd1:    out[5:4] = code;
         2'd2:    out[3:2] = code;
         default: out[1:0] = code;
      endcase
      return out;
   endfunction

   task automatic compare(input string name, input obs_t exp);
      obs_t act;
      act = {phase_o, phase_valid_o, dwell_o, rotations_o,
             err_conflict_o, err_order_o, err_dwell_o};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got phase=%0d valid=%0b dwell=%0d rot=%0d err(c,o,d)=%b ; want phase=%0d valid=%0b dwell=%0d rot=%0d err(c,o,d)=%b",
                  name, $time,
                  act[OW-1 -: 3], act[OW-4], act[CW+10:11], act[10:3], act[2:0],
                  exp[OW-1 -: 3], exp[OW-4], exp[CW+10:11], exp[10:3], exp[2:0]);
      end
   endtask

   // Monitor: one expected entry per sampled edge.
   initial begin
      obs_t  e;
      string n;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            compare(n, e);
         end
      end
   end

   // Drive one sample at the falling edge; also releases any pending reset so
   // the first post-reset sample is exactly this one.
   task automatic sample(input logic [7:0] lights, input string name, input obs_t exp);
      @(negedge clk);
      rst_n = 1'b1;
      {lif.n_lights, lif.s_lights, lif.e_lights, lif.w_lights} = lights;
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   task automatic legal_phase(input logic [2:0] ph, input int n, input bit inc);
      for (int k = 0; k < n; k++) begin
         if (k == 0 && inc) e_rot = e_rot + 8'd1;
         sample(lights_of(ph), "legal", mk(ph, 1'b1, k + 1, e_rot, 3'b000));
      end
   endtask

   // Waits until the queue has drained, then holds reset low and checks the
   // asynchronous clear before any further edge.
   task automatic reset_check(input string name);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      compare(name, mk(3'd0, 1'b0, 0, 8'd0, 3'b000));
      e_rot = 8'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      {lif.n_lights, lif.s_lights, lif.e_lights, lif.w_lights} = 8'h00;

      // Three full rotations from NORTH, plus the closing NORTH sample.
      reset_check("reset_initial");
      for (int r = 0; r < 3; r++)
         for (int ph = 0; ph < 8; ph++)
            legal_phase(3'(ph), DWELL, (r > 0) && (ph == 0));
      legal_phase(3'd0, 1, 1'b1);

      // Conflict on sample 20 (SOUTH, dwell 4), frozen for 50 cycles.
      reset_check("reset_before_conflict");
      legal_phase(3'd0, 8, 1'b0);
      legal_phase(3'd1, 8, 1'b0);
      legal_phase(3'd2, 4, 1'b0);
      sample(8'b10_00_10_00, "conflict_ne", mk(3'd2, 1'b0, 4, 8'd0, 3'b100));
      for (int i = 0; i < 50; i++)
         sample(lights_of(3'd2), "conflict_hold", mk(3'd2, 1'b0, 4, 8'd0, 3'b100));
      reset_check("reset_from_fault");

      // Lock mid-EAST with 3 samples left, then one rotation completes.
      legal_phase(3'd4, 3, 1'b0);
      legal_phase(3'd5, 8, 1'b0);
      legal_phase(3'd6, 8, 1'b0);
      legal_phase(3'd7, 8, 1'b0);
      legal_phase(3'd0, 1, 1'b1);

      // NORTH_Y skipped.
      reset_check("reset_before_order");
      legal_phase(3'd0, 8, 1'b0);
      sample(lights_of(3'd2), "order_skip", mk(3'd0, 1'b0, 8, 8'd0, 3'b010));

      // NORTH_Y one sample short.
      reset_check("reset_before_short");
      legal_phase(3'd0, 8, 1'b0);
      legal_phase(3'd1, 7, 1'b0);
      sample(lights_of(3'd2), "dwell_short", mk(3'd1, 1'b0, 7, 8'd0, 3'b001));

      // WEST held 9 samples; dwell saturates at DWELL.
      reset_check("reset_before_long");
      legal_phase(3'd5, 1, 1'b0);
      legal_phase(3'd6, 8, 1'b0);
      sample(lights_of(3'd6), "dwell_long", mk(3'd6, 1'b0, 8, 8'd0, 3'b001));
      sample(lights_of(3'd6), "dwell_long_hold", mk(3'd6, 1'b0, 8, 8'd0, 3'b001));

      // Illegal 11 on WEST while tracking.
      reset_check("reset_before_illegal");
      legal_phase(3'd0, 2, 1'b0);
      legal_phase(3'd1, 3, 1'b0);
      sample(8'b00_00_00_11, "illegal_w11", mk(3'd1, 1'b0, 3, 8'd0, 3'b100));

      // Short reset pulse inside FAULT, released before the next edge.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      compare("pulse_reset", mk(3'd0, 1'b0, 0, 8'd0, 3'b000));
      #1;
      rst_n = 1'b1;

      // All-red straight out of IDLE.
      sample(8'h00, "all_red_idle", mk(3'd0, 1'b0, 0, 8'd0, 3'b100));

      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
